// File: rtl/asu_ddr5_ca_decoder_mr.sv
// DDR5 CA/CS forwarder with two-cycle MRW/WRITE decode, per-rank MR0/MR8/MR50 shadow,
// MRW multicast, tMRD busy window and one-cycle write descriptors / error pulses.
module asu_ddr5_ca_decoder_mr #(
    parameter  int pNUM_RANK = 2,
    parameter  int pCA_W     = 14,
    parameter  int pTMRD     = 8,
    localparam int pRANK_W   = (pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [pCA_W-1:0]     dfi_address_i,
    input  logic [pNUM_RANK-1:0] dfi_cs_i,
    output logic [pCA_W-1:0]     command_address_o,
    output logic [pNUM_RANK-1:0] chip_select_o,
    output logic                 wr_valid_o,
    output logic [pRANK_W-1:0]   wr_rank_o,
    output logic [1:0]           wr_bl_o,
    output logic [7:0]           pre_pattern_o,
    output logic [2:0]           pre_cycle_o,
    output logic [1:0]           post_cycle_o,
    output logic                 dram_crc_en_o,
    output logic                 mrw_busy_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MRW_2ND = 2'd1,
        ST_WR_2ND  = 2'd2
    } state_t;

    localparam logic [4:0] OPC_MRW   = 5'b00101;
    localparam logic [4:0] OPC_WRITE = 5'b01101;
    localparam logic [3:0] TMRD_LOAD = 4'(pTMRD);

    state_t                 r_state;
    logic [7:0]             r_mr;
    logic [pNUM_RANK-1:0]   r_mask;
    logic [pRANK_W-1:0]     r_rank;
    logic [3:0]             r_busy_cnt;

    logic [1:0]             r_sh_bl   [pNUM_RANK];
    logic [7:0]             r_sh_pat  [pNUM_RANK];
    logic [2:0]             r_sh_pre  [pNUM_RANK];
    logic [1:0]             r_sh_post [pNUM_RANK];
    logic                   r_sh_crc  [pNUM_RANK];

    logic [pCA_W-1:0]       r_ca;
    logic [pNUM_RANK-1:0]   r_cs;
    logic                   r_wr_valid;
    logic [pRANK_W-1:0]     r_wr_rank;
    logic [1:0]             r_wr_bl;
    logic [7:0]             r_pat;
    logic [2:0]             r_pre;
    logic [1:0]             r_post;
    logic                   r_crc;
    logic                   r_err;
    logic [1:0]             r_err_code;

    logic                   w_any_cs_lo;
    logic                   w_all_cs_hi;
    logic [2:0]             w_cs_lo_cnt;
    logic [pRANK_W-1:0]     w_cs_idx;
    logic                   w_is_mrw;
    logic                   w_is_wr;
    logic                   w_busy;
    logic                   w_mrw_commit;
    logic                   w_wr_issue;
    logic                   w_err_abort;
    logic                   w_err_multi;
    logic                   w_err_tmrd;
    logic [1:0]             w_err_code;

    always_comb begin
        w_cs_lo_cnt = '0;
        w_cs_idx    = '0;
        for (int i = pNUM_RANK - 1; i >= 0; i--) begin
            if (!dfi_cs_i[i]) begin
                w_cs_lo_cnt = w_cs_lo_cnt + 3'd1;
                w_cs_idx    = pRANK_W'(unsigned'(i));
            end
        end
    end

    assign w_any_cs_lo  = ~&dfi_cs_i;
    assign w_all_cs_hi  = &dfi_cs_i;
    assign w_is_mrw     = (dfi_address_i[4:0] == OPC_MRW);
    assign w_is_wr      = (dfi_address_i[4:0] == OPC_WRITE);
    assign w_busy       = (r_busy_cnt != 4'd0);

    assign w_mrw_commit = (r_state == ST_MRW_2ND) && w_all_cs_hi && !dfi_address_i[10];
    assign w_wr_issue   = (r_state == ST_WR_2ND) && w_all_cs_hi;

    // Only one code per cycle: abort (10) beats multi-CS (01) beats tMRD (11).
    assign w_err_abort  = ((r_state == ST_MRW_2ND) && !w_mrw_commit) ||
                          ((r_state == ST_WR_2ND)  && !w_wr_issue);
    assign w_err_multi  = (r_state == ST_IDLE) && w_any_cs_lo && w_is_wr && (w_cs_lo_cnt > 3'd1);
    assign w_err_tmrd   = (r_state == ST_IDLE) && w_any_cs_lo && w_is_wr && w_busy;
    assign w_err_code   = w_err_abort ? 2'b10 :
                          w_err_multi ? 2'b01 :
                          w_err_tmrd  ? 2'b11 : 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_mr       <= '0;
            r_mask     <= '0;
            r_rank     <= '0;
            r_busy_cnt <= '0;
            for (int r = 0; r < pNUM_RANK; r++) begin
                r_sh_bl[r]   <= 2'b00;
                r_sh_pat[r]  <= 8'h02;
                r_sh_pre[r]  <= 3'b010;
                r_sh_post[r] <= 2'b01;
                r_sh_crc[r]  <= 1'b0;
            end
            r_ca       <= '0;
            r_cs       <= '1;
            r_wr_valid <= 1'b0;
            r_wr_rank  <= '0;
            r_wr_bl    <= 2'b00;
            r_pat      <= 8'h02;
            r_pre      <= 3'b010;
            r_post     <= 2'b01;
            r_crc      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else if (!enable_i) begin
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ca       <= dfi_address_i;
            r_cs       <= dfi_cs_i;
            r_wr_valid <= 1'b0;
            r_err      <= (w_err_code != 2'b00);
            if (w_err_code != 2'b00) begin
                r_err_code <= w_err_code;
            end

            if (w_mrw_commit) begin
                r_busy_cnt <= TMRD_LOAD;
            end else if (w_busy) begin
                r_busy_cnt <= r_busy_cnt - 4'd1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_cs_lo && w_is_mrw) begin
                        r_mr    <= dfi_address_i[12:5];
                        r_mask  <= ~dfi_cs_i;
                        r_state <= ST_MRW_2ND;
                    end else if (w_any_cs_lo && w_is_wr && (w_cs_lo_cnt == 3'd1)) begin
                        r_rank  <= w_cs_idx;
                        r_state <= ST_WR_2ND;
                    end
                end
                ST_MRW_2ND: begin
                    r_state <= ST_IDLE;
                    if (w_mrw_commit) begin
                        for (int r = 0; r < pNUM_RANK; r++) begin
                            if (r_mask[r]) begin
                                case (r_mr)
                                    8'd0: r_sh_bl[r] <= dfi_address_i[1:0];
                                    8'd8: begin
                                        // OP[4:3] = 00 leaves the preamble untouched; postamble always follows OP[7].
                                        case (dfi_address_i[4:3])
                                            2'b01: begin r_sh_pat[r] <= 8'h02; r_sh_pre[r] <= 3'b010; end
                                            2'b10: begin r_sh_pat[r] <= 8'h02; r_sh_pre[r] <= 3'b011; end
                                            2'b11: begin r_sh_pat[r] <= 8'h0A; r_sh_pre[r] <= 3'b100; end
                                            default: ;
                                        endcase
                                        r_sh_post[r] <= dfi_address_i[7] ? 2'b10 : 2'b01;
                                    end
                                    8'd50: r_sh_crc[r] <= dfi_address_i[2] | dfi_address_i[1];
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                ST_WR_2ND: begin
                    r_state <= ST_IDLE;
                    if (w_wr_issue) begin
                        r_wr_valid <= 1'b1;
                        r_wr_rank  <= r_rank;
                        r_wr_bl    <= dfi_address_i[5] ? r_sh_bl[r_rank] : 2'b01;
                        r_pat      <= r_sh_pat[r_rank];
                        r_pre      <= r_sh_pre[r_rank];
                        r_post     <= r_sh_post[r_rank];
                        r_crc      <= r_sh_crc[r_rank];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign command_address_o = r_ca;
    assign chip_select_o     = r_cs;
    assign wr_valid_o        = r_wr_valid;
    assign wr_rank_o         = r_wr_rank;
    assign wr_bl_o           = r_wr_bl;
    assign pre_pattern_o     = r_pat;
    assign pre_cycle_o       = r_pre;
    assign post_cycle_o      = r_post;
    assign dram_crc_en_o     = r_crc;
    assign mrw_busy_o        = w_busy;
    assign err_o             = r_err;
    assign err_code_o        = r_err_code;

endmodule
